// File: rtl/skip_adder8_seq_ctrl.sv
// Multi-precision add/subtract sequencer: streams NBYTES-wide operands LSB-first
// through an external combinational 8-bit slice, chaining carry through a register.
module skip_adder8_seq_ctrl #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [8*NBYTES-1:0]   req_a,
    input  logic [8*NBYTES-1:0]   req_b,
    input  logic                  req_ci,
    input  logic                  req_sub,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_ci,
    input  logic [7:0]            add_s,
    input  logic                  add_co,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [8*NBYTES-1:0]   rsp_sum,
    output logic                  rsp_co,
    output logic                  rsp_ovf,
    output logic                  busy
);

    localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [IDX_W-1:0]        r_idx;
    logic [NBYTES-1:0][7:0]  r_a;
    logic [NBYTES-1:0][7:0]  r_b;
    logic [NBYTES-1:0][7:0]  r_sum;
    logic                    r_carry;
    logic                    r_sub;
    logic                    r_co;
    logic                    r_ovf;
    logic                    r_req_ready;
    logic                    r_rsp_valid;
    logic                    r_busy;
    logic                    w_accept;
    logic                    w_run;
    logic                    w_last;

    assign w_run    = (r_state == S_RUN);
    assign w_accept = (r_state == S_IDLE) && req_valid;
    assign w_last   = (r_idx == IDX_W'(NBYTES - 1));

    // Slice is only driven while a limb is in flight
    assign add_a  = w_run ? r_a[r_idx] : 8'd0;
    assign add_b  = w_run ? r_b[r_idx] : 8'd0;
    assign add_ci = w_run ? r_carry    : 1'b0;

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign busy      = r_busy;
    assign rsp_sum   = r_sum;
    assign rsp_co    = r_co;
    assign rsp_ovf   = r_ovf;

    // State register plus handshake flags registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == S_IDLE);
            r_rsp_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Subtraction runs as A + ~B + ~borrow; flags are folded back at the last limb
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= req_a;
            r_b     <= req_sub ? ~req_b : req_b;
            r_carry <= req_ci ^ req_sub;
            r_sub   <= req_sub;
            r_idx   <= '0;
        end else if (w_run) begin
            r_sum[r_idx] <= add_s;
            r_carry      <= add_co;
            if (w_last) begin
                r_idx <= '0;
                r_co  <= r_sub ^ add_co;
                r_ovf <= (r_a[NBYTES-1][7] == r_b[NBYTES-1][7]) &&
                         (add_s[7] != r_a[NBYTES-1][7]);
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

endmodule
